oled_pixel_streamer: RTL and testbench
======================================

OLED_PIXEL_STREAMER -- requirements
Module: oled_pixel_streamer

Interface
REQ-001 Parameter: WIDTH, 96, pixels per line.
REQ-002 Parameter: HEIGHT, 64, lines per frame.
REQ-003 Port: clk  input  1  system clock, 100 MHz; sole clock, all logic on rising edge.
REQ-004 Port: rst_n  input  1  reset; one clock; synchronous, active-low.
REQ-005 Port: enable  input  1  level; high requests frame scanning.
REQ-006 Port: x  output  7  scan column presented to the pixel generator.
REQ-007 Port: y  output  7  scan row presented to the pixel generator.
REQ-008 Port: pixel_in  input  16  RGB565 colour returned by the generator for the x/y of the previous cycle.
REQ-009 Port: out_data  output  16  RGB565 pixel toward the OLED driver.
REQ-010 Port: out_valid  output  1  out_data holds a pixel.
REQ-011 Port: out_ready  input  1  driver accepts the pixel this cycle.
REQ-012 Port: out_first  output  1  qualifies out_data as pixel (0,0).
REQ-013 Port: out_last  output  1  qualifies out_data as pixel (WIDTH-1,HEIGHT-1).
REQ-014 Port: frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-015 States: IDLE, SCAN, DRAIN.
REQ-016 IDLE: x=y=0. enable=1 moves to SCAN on the next edge.
REQ-017 Issue: in SCAN, issue occurs in a cycle when (FIFO count + in-flight) <= 1. In-flight is 1 when an issue occurred in the previous cycle.
REQ-018 Issue data: coordinate is the current x/y. x increments after the issue. At WIDTH-1, x wraps to 0 and y increments.
REQ-019 Capture: pixel_in is captured exactly one cycle after its issue and pushed into a 2-entry FIFO. Its first/last tags are derived from the issued coordinate.
REQ-020 Last issue: after issuing (WIDTH-1,HEIGHT-1), the state moves to DRAIN and x/y return to 0.
REQ-021 DRAIN exit: when the FIFO is empty, in-flight=0 and the last pixel has been accepted:
  - frame_done pulses for 1 cycle;
  - the next state is SCAN if enable=1, else IDLE.
REQ-022 enable deasserted mid-frame: no effect; the frame completes in full. Partial frames are never emitted.
REQ-023 Handshake: a pixel transfers when out_valid && out_ready. out_data, out_first and out_last are stable while out_valid=1 && out_ready=0.
REQ-024 FIFO flags: the FIFO never overflows, and the credit rule alone guarantees this. A push into a full FIFO is a design error flagged by an assertion.
REQ-025 Simultaneous push and pop: both occur in the same cycle and count is unchanged.
REQ-026 Ordering: pixels are emitted strictly in raster order, x fastest.
REQ-027 Throughput: with out_ready held high, the block sustains at least 1 pixel per 2 cycles. A frame completes within 2*WIDTH*HEIGHT+4 cycles of leaving IDLE.
REQ-028 Latency: the first out_valid occurs 2 cycles after entering SCAN.

Reset
REQ-029 Reset state: while rst_n=0 at a clock edge, the block enters IDLE, and x=0, y=0.
REQ-030 Reset outputs: out_valid=0, out_first=0, out_last=0, frame_done=0, out_data=16'h0000.
REQ-031 Reset internals: the FIFO is emptied and in-flight is cleared.
REQ-032 Reset mid-frame: any partial frame is discarded. No frame_done is produced for it.

Structure
REQ-033 Shared package oled_pkg:
  - OLED_WIDTH=96, OLED_HEIGHT=64;
  - RGB565 colour constants;
  - state encoding.
REQ-034 Sub-module pixel_fifo2: 2-entry FIFO, 18 bits wide (data + first + last), with push/pop/full/empty/count. It is the only natural sub-module.
REQ-035 All other logic lives in oled_pixel_streamer. There are no derived clocks; pacing uses the handshake only.

Verification
REQ-036 Full frame: pixel_in = {2'b0,y[6:0],x[6:0]} delayed 1 cycle, enable=1, out_ready=1.
  - 6144 pixels arrive in raster order;
  - first word 16'h0000 with out_first=1;
  - last word {2'b0,7'd63,7'd95} with out_last=1;
  - one frame_done pulse follows.
REQ-037 Backpressure: out_ready=0 for 50 cycles mid-frame.
  - out_data is held stable;
  - issues stop within 2 cycles;
  - no pixel is lost or duplicated;
  - resuming out_ready completes the frame correctly.
REQ-038 Random out_ready (50%):
  - sequence equals the golden raster;
  - the FIFO-full push assertion never fires.
REQ-039 enable dropped at pixel 1000:
  - the frame finishes at 6144 pixels with frame_done;
  - the block returns to IDLE with out_valid=0.
REQ-040 rst_n pulsed low 1 cycle at pixel 3000:
  - next cycle all outputs equal their reset values;
  - with enable=1, a fresh frame starts at (0,0) with out_first=1.
REQ-041 enable held high for 2 frames:
  - the second frame starts with no gap beyond 2 cycles after frame_done;
  - frame_done pulses exactly twice.

Source files
------------

// File: rtl/oled_pixel_streamer_pkg.sv
// Shared definitions for the OLED pixel streamer.
// Contents: panel geometry, RGB565 colour constants, scan FSM state
// encoding and the word format held in the output FIFO.
package oled_pkg;

   localparam int OLED_WIDTH  = 96;
   localparam int OLED_HEIGHT = 64;
   localparam int FIFO_DEPTH  = 2;

   localparam logic [15:0] RGB565_BLACK = 16'h0000;
   localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
   localparam logic [15:0] RGB565_RED   = 16'hF800;
   localparam logic [15:0] RGB565_GREEN = 16'h07E0;
   localparam logic [15:0] RGB565_BLUE  = 16'h001F;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // One FIFO entry: colour plus frame-boundary tags (18 bits total).
   typedef struct packed {
      logic [15:0] data;
      logic        first;
      logic        last;
   } fifo_word_t;

endpackage

// File: rtl/oled_pixel_streamer_if.sv
// Pixel stream toward the OLED driver (valid/ready handshake).
// master: streamer side, drives data/valid/first/last, samples ready.
// slave : driver side.
interface oled_pixel_streamer_if;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_first;
   logic        out_last;

   modport master (output out_data, output out_valid, output out_first,
                   output out_last, input out_ready);
   modport slave  (input out_data, input out_valid, input out_first,
                   input out_last, output out_ready);
endinterface

// File: rtl/oled_pixel_streamer_fifo.sv
// pixel_fifo2: two-entry FIFO of tagged pixels.
// Ports: clk, rst_n (sync, active-low), push/push_data, pop/pop_data
// (head, valid while !empty), full, empty, count (0..2).
module pixel_fifo2
   import oled_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  fifo_word_t push_data,
   input  logic       pop,
   output fifo_word_t pop_data,
   output logic       full,
   output logic       empty,
   output logic [1:0] count
);

   fifo_word_t mem_reg [FIFO_DEPTH];
   logic       wr_ptr_reg;
   logic       rd_ptr_reg;
   logic [1:0] count_reg;
   logic       do_push;
   logic       do_pop;

   assign full     = (count_reg == 2'd2);
   assign empty    = (count_reg == 2'd0);
   assign count    = count_reg;
   assign pop_data = mem_reg[rd_ptr_reg];
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_reg[i] <= '0;
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else begin
         if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
            wr_ptr_reg          <= ~wr_ptr_reg;
         end
         if (do_pop) rd_ptr_reg <= ~rd_ptr_reg;
         // Simultaneous push and pop leaves the count unchanged.
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 2'd1;
            2'b01:   count_reg <= count_reg - 2'd1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         push_into_full : assert (!(push && full));
      end
   end

endmodule

// File: rtl/oled_pixel_streamer.sv
// oled_pixel_streamer: raster-scans x/y toward a pixel generator, captures
// the returned colour one cycle later and streams it to the OLED driver.
// Ports: clk, rst_n (sync, active-low), enable (frame request level),
// x/y (scan coordinate), pixel_in (colour for previous cycle's x/y),
// out_bus (data/valid/ready/first/last stream), frame_done (1-cycle pulse).
module oled_pixel_streamer
   import oled_pkg::*;
#(
   parameter int WIDTH  = OLED_WIDTH,
   parameter int HEIGHT = OLED_HEIGHT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   output logic [6:0]           x,
   output logic [6:0]           y,
   input  logic [15:0]          pixel_in,
   oled_pixel_streamer_if.master out_bus,
   output logic                 frame_done
);

   state_t     state_reg, state_next;
   logic [6:0] x_reg, x_next;
   logic [6:0] y_reg, y_next;
   logic       inflight_reg;
   logic       tag_first_reg, tag_last_reg;
   logic       issue;
   logic       at_first, at_last_col, at_last_row;

   fifo_word_t push_word, head_word;
   logic       fifo_full, fifo_empty, fifo_pop;
   logic [1:0] fifo_count;

   assign at_first    = (x_reg == 7'd0) && (y_reg == 7'd0);
   assign at_last_col = (x_reg == 7'(WIDTH - 1));
   assign at_last_row = (y_reg == 7'(HEIGHT - 1));

   always_comb begin
      state_next = state_reg;
      x_next     = x_reg;
      y_next     = y_reg;
      issue      = 1'b0;
      frame_done = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            x_next = 7'd0;
            y_next = 7'd0;
            if (enable) state_next = ST_SCAN;
         end
         ST_SCAN: begin
            // Credit rule: buffered plus in-flight pixels may not exceed
            // the FIFO depth once the new pixel lands.
            issue = (({1'b0, fifo_count} + {2'b00, inflight_reg}) <= 3'd1);
            if (issue) begin
               if (at_last_col) begin
                  x_next = 7'd0;
                  if (at_last_row) begin
                     y_next     = 7'd0;
                     state_next = ST_DRAIN;
                  end else begin
                     y_next = y_reg + 7'd1;
                  end
               end else begin
                  x_next = x_reg + 7'd1;
               end
            end
         end
         ST_DRAIN: begin
            // Empty FIFO with nothing in flight means the last pixel left.
            if (fifo_empty && !inflight_reg) begin
               frame_done = 1'b1;
               state_next = enable ? ST_SCAN : ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         x_reg         <= 7'd0;
         y_reg         <= 7'd0;
         inflight_reg  <= 1'b0;
         tag_first_reg <= 1'b0;
         tag_last_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         x_reg         <= x_next;
         y_reg         <= y_next;
         inflight_reg  <= issue;
         tag_first_reg <= issue && at_first;
         tag_last_reg  <= issue && at_last_col && at_last_row;
      end
   end

   assign push_word.data  = pixel_in;
   assign push_word.first = tag_first_reg;
   assign push_word.last  = tag_last_reg;
   assign fifo_pop        = !fifo_empty && out_bus.out_ready;

   pixel_fifo2 u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight_reg),
      .push_data (push_word),
      .pop       (fifo_pop),
      .pop_data  (head_word),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (rst_n) begin
         credit_overrun : assert (!(inflight_reg && fifo_full));
      end
   end

   // Outputs are forced to zero when no pixel is held.
   assign x                 = x_reg;
   assign y                 = y_reg;
   assign out_bus.out_valid = !fifo_empty;
   assign out_bus.out_data  = fifo_empty ? 16'h0000 : head_word.data;
   assign out_bus.out_first = !fifo_empty && head_word.first;
   assign out_bus.out_last  = !fifo_empty && head_word.last;

endmodule

// File: tb/tb_oled_pixel_streamer.sv
module tb_oled_pixel_streamer;

   localparam int W   = 96;
   localparam int H   = 64;
   localparam int NPX = W * H;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [6:0]  x, y;
   logic [15:0] pixel_in = 16'h0000;
   logic        frame_done;

   oled_pixel_streamer_if bus ();

   oled_pixel_streamer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .x          (x),
      .y          (y),
      .pixel_in   (pixel_in),
      .out_bus    (bus),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // Pixel generator: colour encodes the coordinate, one cycle late.
   always @(posedge clk) pixel_in <= {2'b00, y, x};

   int checks_cnt = 0;
   int errors_cnt = 0;
   int pix_idx    = 0;
   int frame_cnt  = 0;
   int cyc        = 0;
   int fd_cyc     = 0;
   int fv_cyc     = 0;
   bit seen_first = 1'b0;
   int ready_mode = 0;   // 0 always ready, 1 random, 2 stalled

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         errors_cnt++;
         $display("FAIL %s got %0h expected %0h (cycle %0d pixel %0d)", tag, got, exp, cyc, pix_idx);
      end
   endtask

   // Golden raster: pixel k sits at column k%W, row k/W.
   function automatic logic [17:0] model(input int k);
      logic [6:0] px, py;
      px = 7'(k % W);
      py = 7'(k / W);
      return {2'b00, py, px, (k == 0), (k == NPX - 1)};
   endfunction

   // Ready driver applies its value shortly after each edge.
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = 1'b0;
         endcase
      end
   end

   // Monitor: every held pixel must be the next raster pixel.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            pix_idx    = 0;
            seen_first = 1'b0;
         end else begin
            if (bus.out_valid) begin
               check("pixel", {14'b0, bus.out_data, bus.out_first, bus.out_last},
                     {14'b0, model(pix_idx)});
               if (pix_idx == 0 && !seen_first) begin
                  fv_cyc     = cyc;
                  seen_first = 1'b1;
               end
               if (bus.out_ready) pix_idx++;
            end
            if (frame_done) begin
               check("frame_len", pix_idx, NPX);
               pix_idx    = 0;
               seen_first = 1'b0;
               fd_cyc     = cyc;
               frame_cnt++;
            end
         end
      end
   end

   task automatic check_reset(input string tag);
      check({tag, "_valid"}, bus.out_valid, 0);
      check({tag, "_first"}, bus.out_first, 0);
      check({tag, "_last"},  bus.out_last, 0);
      check({tag, "_data"},  bus.out_data, 0);
      check({tag, "_done"},  frame_done, 0);
      check({tag, "_x"},     x, 0);
      check({tag, "_y"},     y, 0);
   endtask

   task automatic wait_pix(input int target, input int budget);
      int n = 0;
      while (pix_idx < target && n < budget) begin
         @(posedge clk); #1; n++;
      end
      if (pix_idx < target) check("wait_pix_timeout", pix_idx, target);
   endtask

   task automatic wait_frame(input int budget, output int elapsed);
      int start = frame_cnt;
      elapsed = 0;
      while (frame_cnt == start && elapsed < budget) begin
         @(posedge clk); #1; elapsed++;
      end
      if (frame_cnt == start) check("wait_frame_timeout", frame_cnt, start + 1);
   endtask

   initial begin
      int n, el, k, stall_idx;
      rst_n  = 1'b0;
      enable = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle_valid", bus.out_valid, 0);

      // Frame 1 with ready high: latency and frame time.
      enable = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!bus.out_valid && n < 10);
      check("latency", n, 3);
      wait_frame(3 * NPX, el);
      check("frame_time_ok", (n + el) <= 2 * NPX + 5, 1);

      // Frame 2 follows back to back; enable drops at pixel 1000.
      wait_pix(1, 20);
      check("frame_gap_ok", (fv_cyc - fd_cyc) <= 3, 1);
      wait_pix(1000, 3 * NPX);
      enable = 1'b0;
      wait_frame(3 * NPX, el);
      check("frames_after_two", frame_cnt, 2);
      repeat (10) @(posedge clk);
      #1;
      check("idle_after_drop", bus.out_valid, 0);
      check("idle_x", x, 0);
      check("frames_still_two", frame_cnt, 2);

      // Frame 3: 50-cycle stall mid-frame, then random ready.
      enable = 1'b1;
      wait_pix(2000, 3 * NPX);
      ready_mode = 2;
      repeat (3) @(posedge clk);
      #1;
      stall_idx = pix_idx;
      k = stall_idx + 2;
      check("stall_xy_early", {y, x}, {7'(k / W), 7'(k % W)});
      repeat (47) @(posedge clk);
      #1;
      check("stall_xy_late", {y, x}, {7'(k / W), 7'(k % W)});
      check("stall_no_accept", pix_idx, stall_idx);
      ready_mode = 1;
      wait_frame(6 * NPX, el);

      // Frame 4: reset pulse at pixel 3000, then a fresh frame.
      wait_pix(3000, 6 * NPX);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check_reset("midreset");
      wait_pix(10, 100);
      enable = 1'b0;
      wait_frame(6 * NPX, el);
      check("frames_total", frame_cnt, 4);
      repeat (10) @(posedge clk);
      #1;
      check("final_idle_valid", bus.out_valid, 0);
      check("final_frames", frame_cnt, 4);

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
